ram_mp_param: RTL and testbench
===============================

Name: ram_mp_param

Overview:
- Parametrised multi-read-port, single-write-port synchronous RAM.
- Next generation of the team's 8x16 dual-read register RAM.
- Adds configurable width, depth and read-port count, plus byte-enable writes, registered reads with valid flags, selectable write-through bypass, and a hardware clear sequencer.
- Used as register file / scratch memory beside the datapath.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write to a read address is visible in that read (write-first); 0 = read returns old data (read-first).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables; bit k covers d_in[8k+7:8k].
- d_in  in  DATA_W  write data.
- clr  in  1  request a full memory clear.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses slice i.
- d_out  out  NUM_RD*DATA_W  packed registered read data.
- rd_valid  out  NUM_RD  per-port: d_out slice was updated this cycle.
- busy  out  1  clear sequence in progress.
- wr_drop  out  1  one-cycle pulse: a write was discarded.

Behaviour:
- Reset (any cycle, including mid-clear):
  - state <= CLEAR, clr_ptr <= 0.
  - d_out <= 0, rd_valid <= 0, wr_drop <= 0, busy <= 1.
  - Memory contents are not touched while reset is held.
- CLEAR state:
  - Each cycle with reset low writes 0 to mem[clr_ptr], then clr_ptr++.
  - After writing DEPTH-1: state <= READY and busy <= 0 on the same edge.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
  - wr is ignored; wr_drop = 1 the next cycle for each ignored wr.
  - rd_en is ignored: rd_valid = 0 and d_out holds its value.
  - clr is ignored.
- READY state:
  - clr = 1 -> CLEAR with clr_ptr <= 0; busy = 1 from the next cycle.
  - Any wr or rd_en in that same cycle is still serviced.
  - Write: wr = 1 updates only the bytes with wr_be[k] = 1. wr_be = 0 is a legal no-op and does not raise wr_drop.
  - Read latency is 1 cycle: rd_en[i] at edge N gives d_out[i] and rd_valid[i] = 1 after edge N. rd_en[i] = 0 gives rd_valid[i] = 0 and d_out[i] holds.
- Read/write collision (same address, same cycle):
  - BYPASS = 1: each byte comes from d_in if wr_be[k], else from the old memory byte.
  - BYPASS = 0: old word.
- Any number of ports may read the same address in the same cycle.
- Addresses always wrap within DEPTH (no out-of-range handling needed).
- wr_drop is a registered pulse; it is high for one cycle per dropped write.

Decomposition:
- Shared package ram_mp_pkg:
  - state enum {CLEAR, READY}.
  - Function for byte-enable width (DATA_W/8).
  - Function merge_bytes(old, new, be) used by both the write path and the bypass path.
- One sub-module ram_clear_seq:
  - Owns state, clr_ptr and busy.
  - Outputs the clear write strobe/address and a ready flag.
- The top level holds the memory array and NUM_RD read slices in a generate loop.

Test Plan (DATA_W=16, ADDR_W=3, NUM_RD=2 unless stated):
1. Reset for 1 cycle, then release -> busy = 1 for exactly 8 cycles, then 0. Reading addresses 0..7 on both ports -> 16'h0000, with rd_valid = 2'b11.
2. Write 16'hA5A5 at addr 0 and 16'h5A5A at addr 1 (be = 2'b11). Then in one cycle read port0 addr 0 and port1 addr 1 -> next cycle d_out = {16'h5A5A, 16'hA5A5}, rd_valid = 2'b11. Following idle cycle -> rd_valid = 0, d_out held.
3. Byte enable: write 16'h1234 at addr 0 with be = 2'b01 -> read addr 0 gives 16'hA534.
4. Collision: write 16'hFFFF at addr 0 with be = 2'b10 while port0 reads addr 0 -> BYPASS=1 gives 16'hFF34; BYPASS=0 build gives 16'hA534, and a later read gives 16'hFF34.
5. Pulse clr, then wr 16'hBEEF at addr 2 during CLEAR -> wr_drop = 1 for one cycle. After busy falls (8 cycles), reading addr 1 and addr 2 gives 16'h0000.
6. Assert reset when clr_ptr = 4 -> sequence restarts: busy = 1 for a full 8 cycles after release, d_out = 0 and rd_valid = 0 during reset.

Source files
------------

// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared types and byte-merge helpers for the multi-port RAM
package ram_mp_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / 8;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] r;
        for (int k = 0; k < MAX_BE; k++)
            r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address writing zero after reset or a clr request
module ram_clear_seq
    import ram_mp_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    // Sequence through all addresses, then hand control back; clr restarts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == '1) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end else if (clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end
    end

    assign clr_we   = (state == CLEAR) && !reset;
    assign clr_addr = clr_ptr;
    assign ready    = (state == READY);

endmodule

// File: rtl/ram_mp_param.sv
// ram_mp_param: parametrised byte-enable RAM with NUM_RD registered read ports
module ram_mp_param
    import ram_mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [be_width(DATA_W)-1:0]  wr_be,
    input  logic [DATA_W-1:0]            d_in,
    input  logic                         clr,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     d_out,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         busy,
    output logic                         wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;
    logic [DATA_W-1:0] merged;

    ram_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .busy     (busy)
    );

    // New word at wr_addr: shared by the array write and the write-first bypass
    assign merged = DATA_W'(merge_bytes(MAX_W'(mem[wr_addr]), MAX_W'(d_in), MAX_BE'(wr_be)));

    // Array update: clear sequencer owns the port in CLEAR, user writes in READY
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we)
                mem[clr_addr] <= '0;
            else if (ready && wr)
                mem[wr_addr] <= merged;
        end
    end

    // Flag writes that arrive while the clear is running
    always_ff @(posedge clk) begin
        if (reset)
            wr_drop <= 1'b0;
        else
            wr_drop <= wr && !ready;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] q;
        logic              v;
        logic              hit;

        assign a   = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit = (BYPASS != 0) && wr && (wr_addr == a);

        // Registered read; data holds whenever the port is idle or the RAM is clearing
        always_ff @(posedge clk) begin
            if (reset) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                v <= ready && rd_en[i];
                if (ready && rd_en[i])
                    q <= hit ? merged : mem[a];
            end
        end

        assign d_out[i*DATA_W +: DATA_W] = q;
        assign rd_valid[i]               = v;
    end

endmodule

// File: tb/tb_ram_mp_param.sv
// tb_ram_mp_param: table-driven and sequenced checks of ram_mp_param
module tb_ram_mp_param;

    localparam int BYP = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [2:0]  wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] d_in;
    logic        clr;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] d_out;
    logic [1:0]  rd_valid;
    logic        busy;
    logic        wr_drop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  wa;
        logic [1:0]  be;
        logic [15:0] din;
        logic [1:0]  re;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [31:0] exp_d;
        logic [1:0]  exp_v;
    } vec_t;

    vec_t vecs[10];

    ram_mp_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .BYPASS(BYP)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .d_in     (d_in),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .d_out    (d_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wr = 0; wr_addr = 0; wr_be = 0; d_in = 0; clr = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        int n;
        logic [15:0] coll;
        logic [31:0] both;
        coll = BYP ? 16'hFF34 : 16'hA534;
        both = BYP ? 32'hCAFE_CAFE : 32'h0000_0000;
        vecs[0] = '{1'b1, 3'd0, 2'b11, 16'hA5A5, 2'b00, 3'd0, 3'd0, 32'h0000_0000, 2'b00};
        vecs[1] = '{1'b1, 3'd1, 2'b11, 16'h5A5A, 2'b00, 3'd0, 3'd0, 32'h0000_0000, 2'b00};
        vecs[2] = '{1'b0, 3'd0, 2'b00, 16'h0000, 2'b11, 3'd0, 3'd1, 32'h5A5A_A5A5, 2'b11};
        vecs[3] = '{1'b0, 3'd0, 2'b00, 16'h0000, 2'b00, 3'd0, 3'd0, 32'h5A5A_A5A5, 2'b00};
        vecs[4] = '{1'b1, 3'd0, 2'b01, 16'h1234, 2'b00, 3'd0, 3'd0, 32'h5A5A_A5A5, 2'b00};
        vecs[5] = '{1'b0, 3'd0, 2'b00, 16'h0000, 2'b01, 3'd0, 3'd0, 32'h5A5A_A534, 2'b01};
        vecs[6] = '{1'b1, 3'd0, 2'b10, 16'hFFFF, 2'b01, 3'd0, 3'd0, {16'h5A5A, coll}, 2'b01};
        vecs[7] = '{1'b0, 3'd0, 2'b00, 16'h0000, 2'b11, 3'd0, 3'd0, 32'hFF34_FF34, 2'b11};
        vecs[8] = '{1'b1, 3'd3, 2'b00, 16'h1111, 2'b10, 3'd0, 3'd3, 32'h0000_FF34, 2'b10};
        vecs[9] = '{1'b1, 3'd3, 2'b11, 16'hCAFE, 2'b11, 3'd3, 3'd3, both, 2'b11};

        // Reset and initial clear
        idle();
        reset = 1;
        cyc(); cyc();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_dout", d_out, 32'h0);
        chk("rst_valid", {30'b0, rd_valid}, 32'd0);
        chk("rst_drop", {31'b0, wr_drop}, 32'd0);
        reset = 0;
        wait_ready(n);
        chk("init_busy_cycles", n, 32'd8);
        for (int a = 0; a < 8; a++) begin
            rd_en = 2'b11;
            rd_addr = {3'(7 - a), 3'(a)};
            cyc();
            chk("init_zero_d", d_out, 32'h0);
            chk("init_zero_v", {30'b0, rd_valid}, 32'd3);
        end
        idle();

        // Table-driven writes, reads, byte enables and collisions
        for (int i = 0; i < 10; i++) begin
            wr = vecs[i].wr; wr_addr = vecs[i].wa; wr_be = vecs[i].be; d_in = vecs[i].din;
            rd_en = vecs[i].re; rd_addr = {vecs[i].a1, vecs[i].a0};
            cyc();
            chk($sformatf("vec%0d_d", i), d_out, vecs[i].exp_d);
            chk($sformatf("vec%0d_v", i), {30'b0, rd_valid}, {30'b0, vecs[i].exp_v});
            chk($sformatf("vec%0d_drop", i), {31'b0, wr_drop}, 32'd0);
        end
        idle();
        rd_en = 2'b01; rd_addr = 6'd0;
        cyc();
        chk("coll_later", d_out, 32'hCAFE_FF34 & {BYP ? 16'hCAFE : 16'h0000, 16'hFFFF});

        // clr pulse, dropped write, reads ignored during clear
        idle();
        clr = 1;
        cyc();
        chk("clr_busy", {31'b0, busy}, 32'd1);
        idle();
        wr = 1; wr_addr = 3'd2; wr_be = 2'b11; d_in = 16'hBEEF; rd_en = 2'b11; rd_addr = {3'd2, 3'd1};
        cyc();
        chk("drop_pulse", {31'b0, wr_drop}, 32'd1);
        chk("clear_rd_v", {30'b0, rd_valid}, 32'd0);
        chk("clear_rd_hold", d_out, 32'hCAFE_FF34 & {BYP ? 16'hCAFE : 16'h0000, 16'hFFFF});
        idle();
        wait_ready(n);
        chk("drop_once", {31'b0, wr_drop}, 32'd0);
        chk("clr_busy_cycles", 32'(n + 1), 32'd8);
        rd_en = 2'b11; rd_addr = {3'd2, 3'd1};
        cyc();
        chk("clr_zero_d", d_out, 32'h0);
        chk("clr_zero_v", {30'b0, rd_valid}, 32'd3);

        // Reset in the middle of a clear
        idle();
        wr = 1; wr_addr = 3'd5; wr_be = 2'b11; d_in = 16'h1357;
        cyc();
        idle();
        rd_en = 2'b01; rd_addr = 6'd5;
        cyc();
        chk("pre_rst_d", d_out, 32'h0000_1357);
        idle();
        clr = 1;
        cyc();
        idle();
        cyc(); cyc(); cyc(); cyc();
        reset = 1; rd_en = 2'b11;
        cyc();
        chk("mid_rst_d", d_out, 32'h0);
        chk("mid_rst_v", {30'b0, rd_valid}, 32'd0);
        cyc();
        chk("mid_rst_busy", {31'b0, busy}, 32'd1);
        reset = 0; rd_en = 0;
        wait_ready(n);
        chk("restart_busy_cycles", n, 32'd8);
        rd_en = 2'b11; rd_addr = {3'd4, 3'd5};
        cyc();
        chk("restart_zero_d", d_out, 32'h0);
        chk("restart_zero_v", {30'b0, rd_valid}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
